// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a sync_fifo read port: pops one word and serialises it per frame.
// Latency: rd_en pulse, then one LOAD cycle, then the start bit begins on tx.
// Backpressure: frames start only from IDLE with tx_enable high and the FIFO non-empty.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  // Baud counter runs 0..CLKS_PER_BIT-1; the bit counter is shared between the
  // data bits (0..WIDTH-1) and the stop bits (0..STOP_BITS-1).
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_INV   = (PARITY_ODD != 0);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q,  baud_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               par_q,   par_d;
  logic               tx_q,    tx_d;
  logic               rd_en_q, rd_en_d;
  logic               done_q,  done_d;

  logic               baud_last;

  assign baud_last  = (baud_q == BAUD_LAST);

  // All serial-side outputs come straight from flops so tx never glitches.
  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = done_q;
  assign busy       = (state_q != S_IDLE);

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; tx_d is the line level for the cycle that follows.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        // Only place the FIFO status and enable are looked at.
        if (tx_enable && !fifo_empty) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
        end
      end

      S_POP: begin
        // FIFO takes the read strobe at the end of this cycle.
        tx_d    = 1'b1;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        // FIFO output is valid now; latch it and start the start bit.
        shift_d = fifo_data;
        par_d   = (^fifo_data) ^ ODD_INV;
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end

      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PAR) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // frame_done is registered, so raise it when entering the final stop cycle.
    if ((state_d == S_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST)) begin
      done_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parameterisations share one stimulus stream.
// Each has its own FIFO read model and a frame-timeline reference model.
// Outputs are compared every cycle on the falling edge, plus literal frame checks.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_enable = 1'b0;

  always #5 clk = ~clk;

  // Shared push stream: every instance's FIFO receives the same words.
  logic [7:0] mem [512];
  int         wp = 0;

  logic [2:0] tx_v, busy_v, rd_v, done_v, empty_v;
  logic [2:0] etx_v, ebusy_v, erd_v, edone_v, mvalid_v;

  int errors = 0;
  int checks = 0;
  int rdcnt [3] = '{0, 0, 0};

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int CPB   = (g == 2) ? 3 : 4;
    localparam int PEN   = (g == 0) ? 0 : 1;
    localparam int PODD  = (g == 2) ? 1 : 0;
    localparam int STOPB = (g == 0) ? 1 : 2;
    localparam int NB    = 1 + 8 + PEN + STOPB;

    logic [7:0] fdat = 8'h00;
    int         rp = 0;
    int         mp = 0;
    int         k = 0;
    int         c = 0;
    int         b = 0;
    logic       act = 1'b0;
    logic [7:0] d = 8'h00;
    logic       e_tx = 1'b1, e_busy = 1'b0, e_rd = 1'b0, e_done = 1'b0, mv = 1'b0;
    logic       tx_w, busy_w, rd_w, done_w;

    assign empty_v[g]  = (rp == wp);
    assign tx_v[g]     = tx_w;
    assign busy_v[g]   = busy_w;
    assign rd_v[g]     = rd_w;
    assign done_v[g]   = done_w;
    assign etx_v[g]    = e_tx;
    assign ebusy_v[g]  = e_busy;
    assign erd_v[g]    = e_rd;
    assign edone_v[g]  = e_done;
    assign mvalid_v[g] = mv;

    fifo_uart_tx #(
      .WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(PEN),
      .PARITY_ODD(PODD), .STOP_BITS(STOPB)
    ) u_dut (
      .clk(clk), .rst(rst), .tx_enable(tx_enable),
      .fifo_empty(empty_v[g]), .fifo_data(fdat),
      .fifo_rd_en(rd_w), .tx(tx_w), .busy(busy_w), .frame_done(done_w)
    );

    // sync_fifo read side: data_out valid the cycle after an accepted rd_en.
    always @(posedge clk) begin
      if (rd_w && (rp != wp)) begin
        fdat <= mem[rp % 512];
        rp   <= rp + 1;
      end
    end

    // Reference: a frame is a timeline k=0 (pop), k=1 (load), then NB bits of CPB cycles.
    always @(posedge clk) begin
      if (!rst) begin
        act = 1'b0;
        k   = 0;
        mv  = 1'b1;
      end else if (!act) begin
        if (tx_enable && !empty_v[g]) begin
          act = 1'b1;
          k   = 0;
          d   = mem[mp % 512];
          mp  = mp + 1;
        end
      end else begin
        k = k + 1;
        if (k - 2 >= NB * CPB) act = 1'b0;
      end
      if (!act) begin
        e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
      end else begin
        e_busy = 1'b1;
        e_rd   = (k == 0);
        if (k < 2) begin
          e_tx = 1'b1; e_done = 1'b0;
        end else begin
          c = k - 2;
          b = c / CPB;
          if (b == 0)                     e_tx = 1'b0;
          else if (b <= 8)                e_tx = d[b-1];
          else if (PEN == 1 && b == 9)    e_tx = (^d) ^ (PODD == 1);
          else                            e_tx = 1'b1;
          e_done = (c == NB * CPB - 1);
        end
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%h want=%h", name, idx, $time, got, want);
    end
  endtask

  // One cycle: advance to the falling edge and compare every instance with its model.
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (mvalid_v[g]) begin
        chk("tx", g, 32'(tx_v[g]), 32'(etx_v[g]));
        chk("busy", g, 32'(busy_v[g]), 32'(ebusy_v[g]));
        chk("rd_en", g, 32'(rd_v[g]), 32'(erd_v[g]));
        chk("frame_done", g, 32'(done_v[g]), 32'(edone_v[g]));
      end
      if (rd_v[g] === 1'b1) rdcnt[g]++;
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wp % 512] = v;
    wp = wp + 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pop(input int g);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (rd_v[g] !== 1'b1 && t < 300);
    chk("pop_seen", g, 32'(rd_v[g]), 32'd1);
  endtask

  // Wait for a pop on instance g, then sample tx mid-bit until frame_done.
  task automatic capture(input int g, output logic [15:0] bits, output int n_done);
    int cpb;
    cpb    = (g == 2) ? 3 : 4;
    bits   = '0;
    n_done = -1;
    wait_pop(g);
    tick();
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (((n - 1) % cpb) == (cpb / 2) && ((n - 1) / cpb) < 16)
        bits[(n - 1) / cpb] = tx_v[g];
      if (done_v[g] === 1'b1) begin
        n_done = n;
        break;
      end
    end
  endtask

  logic [15:0] bits;
  int          nd;

  initial begin
    // Reset held with a non-empty FIFO and enable high.
    rst = 1'b0;
    tx_enable = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tx", i, 32'(tx_v), 32'h7);
      chk("rst_busy", i, 32'(busy_v), 32'h0);
      chk("rst_rd", i, 32'(rd_v), 32'h0);
    end
    rst = 1'b1;

    // 0xA5, 4 clocks per bit, no parity, one stop bit.
    capture(0, bits, nd);
    chk("a5_bits", 0, 32'(bits[9:0]), 32'h34A);
    chk("a5_done_cycle", 0, nd, 40);
    tick();
    chk("a5_idle_busy", 0, 32'(busy_v[0]), 32'h0);
    run(60);

    // Parity: 0x07 even -> parity 1, odd -> parity 0; two stop bits.
    for (int i = 0; i < 4; i++) push(8'h07);
    capture(1, bits, nd);
    chk("even_par_bits", 1, 32'(bits[11:0]), 32'hE0E);
    chk("even_par_done", 1, nd, 48);
    capture(2, bits, nd);
    chk("odd_par_bits", 2, 32'(bits[11:0]), 32'hC0E);
    chk("odd_par_done", 2, nd, 36);
    run(150);

    // Three back-to-back words, exactly three pops each, FIFO drained.
    for (int g = 0; g < 3; g++) rdcnt[g] = 0;
    push(8'h00); push(8'hFF); push(8'h3C);
    run(200);
    for (int g = 0; g < 3; g++) chk("b2b_pops", g, rdcnt[g], 3);
    chk("b2b_empty", 0, 32'(empty_v), 32'h7);

    // Enable low: no pops while the FIFO holds data.
    tx_enable = 1'b0;
    for (int g = 0; g < 3; g++) rdcnt[g] = 0;
    push(8'h5A);
    run(20);
    for (int g = 0; g < 3; g++) chk("dis_pops", g, rdcnt[g], 0);
    chk("dis_tx", 0, 32'(tx_v), 32'h7);
    tx_enable = 1'b1;
    push(8'h96);
    wait_pop(0);
    run(10);
    tx_enable = 1'b0;
    for (int g = 0; g < 3; g++) rdcnt[g] = 0;
    run(80);
    for (int g = 0; g < 3; g++) chk("drop_pops", g, rdcnt[g], 0);
    chk("drop_busy", 0, 32'(busy_v), 32'h0);
    tx_enable = 1'b1;
    run(150);

    // Reset during data bit 3 loses the word; the next one goes out cleanly.
    push(8'hC3); push(8'h3C);
    wait_pop(0);
    tick();
    run(18);
    rst = 1'b0;
    tick();
    chk("midrst_tx", 0, 32'(tx_v), 32'h7);
    chk("midrst_busy", 0, 32'(busy_v), 32'h0);
    chk("midrst_done", 0, 32'(done_v), 32'h0);
    rst = 1'b1;
    capture(0, bits, nd);
    chk("restart_bits", 0, 32'(bits[9:0]), 32'h278);
    chk("restart_done", 0, nd, 40);
    run(150);

    // Random pushes, enable toggles and short resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0 && wp < 500) push(8'($urandom));
      if ($urandom_range(0, 199) == 0) tx_enable = ~tx_enable;
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    tx_enable = 1'b1;
    run(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
